chnl_rx_unpack: RTL and testbench

CHNL_RX_UNPACK -- requirements
Module: chnl_rx_unpack

---
 rtl/chnl_rx_unpack.sv | 174 +++++++++++++++++
 tb/tb_chnl_rx_unpack.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chnl_rx_unpack.sv
// Riffa RX channel receiver: acknowledges a transaction, buffers the incoming
// PCIe-width words and unpacks them into RX_WIDTH slices, least significant first.
//
// state | meaning
// IDLE  | waiting for CHNL_RX while the unpack stage holds no transaction
// ACK   | one-cycle CHNL_RX_ACK pulse, word and slice counts already latched
// RECV  | accepting data words into the buffer until words_left reaches 0
module chnl_rx_unpack #(
    parameter int C_PCI_DATA_WIDTH = 32,
    parameter int RX_WIDTH         = 32,
    parameter int DEPTH            = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic                        CHNL_RX_CLK,
    input  logic                        CHNL_RX,
    output logic                        CHNL_RX_ACK,
    input  logic                        CHNL_RX_LAST,
    input  logic [31:0]                 CHNL_RX_LEN,
    input  logic [30:0]                 CHNL_RX_OFF,
    input  logic [C_PCI_DATA_WIDTH-1:0] CHNL_RX_DATA,
    input  logic                        CHNL_RX_DATA_VALID,
    output logic                        CHNL_RX_DATA_REN,
    output logic                        o_val,
    input  logic                        o_rdy,
    output logic [RX_WIDTH-1:0]         o_data,
    output logic                        o_last
);

    localparam int SPW = C_PCI_DATA_WIDTH / RX_WIDTH;
    localparam int IW  = (SPW > 1) ? $clog2(SPW) : 1;
    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW  = $clog2(DEPTH + 1);

    localparam logic [IW-1:0] IDX_MAX  = IW'(SPW - 1);
    localparam logic [AW-1:0] PTR_MAX  = AW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [32:0]   PCI_BITS = 33'(C_PCI_DATA_WIDTH);
    localparam logic [32:0]   RX_BITS  = 33'(RX_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        RECV = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [32:0] len_bits;
    logic [32:0] words_calc;
    logic [32:0] slices_calc;
    logic [32:0] words_left;
    logic [32:0] slices_left;

    logic [C_PCI_DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [IW-1:0] idx;

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic xfer;
    logic unpack_idle;
    logic start;

    // LAST, OFF and the top LEN bits carry nothing this block uses
    logic unused_inputs;
    assign unused_inputs = ^{CHNL_RX_LAST, CHNL_RX_OFF, CHNL_RX_LEN[31:28]};

    assign CHNL_RX_CLK = clk;

    assign len_bits    = {CHNL_RX_LEN[27:0], 5'b0};
    assign words_calc  = (len_bits + PCI_BITS - 33'd1) / PCI_BITS;
    assign slices_calc = len_bits / RX_BITS;

    assign full        = (count == CNT_FULL);
    assign empty       = (count == '0);
    assign unpack_idle = empty && (slices_left == '0);
    assign push        = CHNL_RX_DATA_VALID && CHNL_RX_DATA_REN;

    // The buffer head is the word being unpacked; it leaves only once fully used
    assign o_val  = !empty && (slices_left != '0);
    assign xfer   = o_val && o_rdy;
    assign o_last = o_val && (slices_left == 33'd1);
    assign o_data = mem[rd_ptr][RX_WIDTH*idx +: RX_WIDTH];
    assign pop    = !empty && ((slices_left == '0) ||
                               (xfer && ((idx == IDX_MAX) || (slices_left == 33'd1))));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        CHNL_RX_ACK      = 1'b0;
        CHNL_RX_DATA_REN = 1'b0;
        start            = 1'b0;
        case (state)
            IDLE: begin
                if (CHNL_RX && unpack_idle) begin
                    start     = 1'b1;
                    state_nxt = ACK;
                end
            end
            ACK: begin
                CHNL_RX_ACK = 1'b1;
                state_nxt   = (words_left != '0) ? RECV : IDLE;
            end
            RECV: begin
                CHNL_RX_DATA_REN = !full;
                if (push && (words_left == 33'd1)) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            words_left  <= '0;
            slices_left <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            idx         <= '0;
        end else begin
            if (start) begin
                words_left  <= words_calc;
                slices_left <= slices_calc;
            end else begin
                if (push) begin
                    words_left <= words_left - 33'd1;
                end
                if (xfer) begin
                    slices_left <= slices_left - 33'd1;
                end
            end

            if (push) begin
                wr_ptr <= (wr_ptr == PTR_MAX) ? '0 : wr_ptr + 1'b1;
            end

            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_MAX) ? '0 : rd_ptr + 1'b1;
                idx    <= '0;
            end else if (xfer) begin
                idx <= idx + 1'b1;
            end

            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: count alone decides what is valid
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= CHNL_RX_DATA;
        end
    end

endmodule

// File: tb/tb_chnl_rx_unpack.sv
// Scoreboard bench for chnl_rx_unpack at 64-bit PCIe words, 32-bit slices, depth 4.
module tb_chnl_rx_unpack;

    localparam int PW = 64;
    localparam int RW = 32;
    localparam int DP = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          CHNL_RX_CLK;
    logic          CHNL_RX;
    logic          CHNL_RX_ACK;
    logic          CHNL_RX_LAST;
    logic [31:0]   CHNL_RX_LEN;
    logic [30:0]   CHNL_RX_OFF;
    logic [PW-1:0] CHNL_RX_DATA;
    logic          CHNL_RX_DATA_VALID;
    logic          CHNL_RX_DATA_REN;
    logic          o_val;
    logic          o_rdy;
    logic [RW-1:0] o_data;
    logic          o_last;

    chnl_rx_unpack #(
        .C_PCI_DATA_WIDTH(PW),
        .RX_WIDTH        (RW),
        .DEPTH           (DP)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .CHNL_RX_CLK       (CHNL_RX_CLK),
        .CHNL_RX           (CHNL_RX),
        .CHNL_RX_ACK       (CHNL_RX_ACK),
        .CHNL_RX_LAST      (CHNL_RX_LAST),
        .CHNL_RX_LEN       (CHNL_RX_LEN),
        .CHNL_RX_OFF       (CHNL_RX_OFF),
        .CHNL_RX_DATA      (CHNL_RX_DATA),
        .CHNL_RX_DATA_VALID(CHNL_RX_DATA_VALID),
        .CHNL_RX_DATA_REN  (CHNL_RX_DATA_REN),
        .o_val             (o_val),
        .o_rdy             (o_rdy),
        .o_data            (o_data),
        .o_last            (o_last)
    );

    always #5 clk = ~clk;

    logic [RW:0] exp_q [$];
    logic [RW:0] mon_e;
    int checks = 0;
    int errors = 0;
    int ack_cnt = 0;
    int acc_cnt = 0;
    int ren_cnt = 0;
    int olast_cnt = 0;
    int ack_lat = 0;
    int olast_at_ack = 0;
    bit rdy_rand = 1'b0;
    logic rdy_fixed = 1'b1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    // Sole driver of o_rdy: random backpressure or a fixed level
    initial begin
        o_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            o_rdy = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fixed;
        end
    end

    always @(negedge clk) begin
        if (CHNL_RX_ACK) ack_cnt++;
        if (CHNL_RX_DATA_REN) ren_cnt++;
        if (CHNL_RX_DATA_VALID && CHNL_RX_DATA_REN) acc_cnt++;
        if (o_val && o_rdy) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_slice: got data %0h last %0b, required no slice", o_data, o_last);
            end else begin
                mon_e = exp_q.pop_front();
                chk("slice_data", 64'(o_data), 64'(mon_e[RW-1:0]));
                chk("slice_last", 64'(o_last), 64'(mon_e[RW]));
            end
            if (o_last) olast_cnt++;
        end
    end

    // Reference: LEN dwords -> ceil(LEN/2) 64-bit words, LEN 32-bit slices taken low half first
    task automatic send(input int len, input int feed, input bit expect_out);
        logic [PW-1:0] w [$];
        logic [PW-1:0] ww;
        int nw;
        int i;
        int guard;
        nw = (len * 32 + PW - 1) / PW;
        for (int k = 0; k < nw; k++) w.push_back({$urandom, $urandom});
        if (expect_out) begin
            for (int k = 0; k < (len * 32) / RW; k++) begin
                ww = w[k / 2];
                exp_q.push_back({k == (len * 32) / RW - 1, (k % 2 == 1) ? ww[63:32] : ww[31:0]});
            end
        end
        @(posedge clk);
        #1;
        CHNL_RX     = 1'b1;
        CHNL_RX_LEN = 32'(len);
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!CHNL_RX_ACK && guard < 400);
        ack_lat = guard;
        olast_at_ack = olast_cnt;
        if (!CHNL_RX_ACK) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: got no ACK after %0d cycles, required ACK", guard);
        end
        @(posedge clk);
        #1;
        CHNL_RX = 1'b0;
        @(negedge clk);
        chk("ack_one_cycle", 64'(CHNL_RX_ACK), 64'd0);
        i = 0;
        guard = 0;
        while (i < feed && guard < 3000) begin
            @(posedge clk);
            #1;
            CHNL_RX_DATA_VALID = ($urandom_range(0, 3) != 0);
            CHNL_RX_DATA       = w[i];
            @(negedge clk);
            if (CHNL_RX_DATA_VALID && CHNL_RX_DATA_REN) i++;
            guard++;
        end
        @(posedge clk);
        #1;
        CHNL_RX_DATA_VALID = 1'b0;
        if (i < feed) begin
            checks++;
            errors++;
            $display("FAIL feed_timeout: got %0d words accepted, required %0d", i, feed);
        end
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 3000) begin
            @(negedge clk);
            g++;
        end
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: got simulation still running, required completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        int r0;
        int c0;
        int ol0;
        int bad;
        int len;
        rst = 1'b1;
        CHNL_RX = 1'b0;
        CHNL_RX_LAST = 1'b0;
        CHNL_RX_LEN = '0;
        CHNL_RX_OFF = '0;
        CHNL_RX_DATA = '0;
        CHNL_RX_DATA_VALID = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ack", 64'(CHNL_RX_ACK), 64'd0);
        chk("rst_ren", 64'(CHNL_RX_DATA_REN), 64'd0);
        chk("rst_oval", 64'(o_val), 64'd0);
        chk("rst_olast", 64'(o_last), 64'd0);
        chk("rx_clk_low", 64'(CHNL_RX_CLK), 64'd0);
        @(posedge clk);
        #1;
        chk("rx_clk_high", 64'(CHNL_RX_CLK), 64'd1);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Two words, full rate output
        a0 = ack_cnt;
        send(4, 2, 1'b1);
        chk("len4_ack_latency", 64'(ack_lat), 64'd2);
        drain();
        chk("len4_ack_count", 64'(ack_cnt - a0), 64'd1);

        // Odd length: upper half of the last word is dropped
        send(3, 2, 1'b1);
        drain();

        // Backpressure: buffer fills at DEPTH words, then REN drops
        rdy_fixed = 1'b0;
        c0 = acc_cnt;
        fork
            send(16, 8, 1'b1);
        join_none
        repeat (40) @(negedge clk);
        chk("bp_accepted", 64'(acc_cnt - c0), 64'(DP));
        chk("bp_ren_low", 64'(CHNL_RX_DATA_REN), 64'd0);
        rdy_fixed = 1'b1;
        wait fork;
        drain();

        // Zero length
        a0 = ack_cnt;
        r0 = ren_cnt;
        send(0, 0, 1'b1);
        repeat (4) @(negedge clk);
        chk("len0_ack_count", 64'(ack_cnt - a0), 64'd1);
        chk("len0_ren_never", 64'(ren_cnt - r0), 64'd0);
        chk("len0_ack_latency", 64'(ack_lat), 64'd2);
        send(2, 1, 1'b1);
        chk("after_len0_latency", 64'(ack_lat), 64'd2);
        drain();

        // Second transaction held off until the first o_last transfers
        rdy_fixed = 1'b0;
        repeat (2) @(negedge clk);
        send(4, 2, 1'b1);
        ol0 = olast_cnt;
        a0 = ack_cnt;
        fork
            send(2, 1, 1'b1);
        join_none
        repeat (20) @(posedge clk);
        chk("no_early_ack", 64'(ack_cnt - a0), 64'd0);
        rdy_fixed = 1'b1;
        wait fork;
        chk("ack_after_olast", 64'(olast_at_ack), 64'(ol0 + 1));
        drain();

        // Reset mid-transaction discards everything
        rdy_fixed = 1'b0;
        repeat (2) @(negedge clk);
        send(16, 2, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_ren", 64'(CHNL_RX_DATA_REN), 64'd0);
        chk("midrst_oval", 64'(o_val), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        rdy_fixed = 1'b1;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (o_val) bad++;
        end
        chk("post_rst_no_oval", 64'(bad), 64'd0);
        c0 = olast_cnt;
        send(2, 1, 1'b1);
        drain();
        chk("post_rst_olast", 64'(olast_cnt - c0), 64'd1);

        // Random lengths with random backpressure
        rdy_rand = 1'b1;
        for (int t = 0; t < 25; t++) begin
            len = $urandom_range(0, 20);
            send(len, (len + 1) / 2, 1'b1);
        end
        rdy_rand = 1'b0;
        rdy_fixed = 1'b1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
